regfile_multiport: RTL and testbench
====================================

Name: regfile_multiport

Overview:
Parametrised general-purpose register file for the 8-bit datapath and its successors.
- NUM_REGS registers of DATA_W bits each.
- Tri-state shared databus port, used for reads and loads.
- Two independent combinational ALU read ports (A/B).
- Dedicated ALU writeback port.
- In-place increment/decrement, used for pointers and loop counters, with wrap detection.
- Per-register zero flags.

Parameters:
DATA_W, 8, register width in bits (>=2)
NUM_REGS, 4, number of registers (>=2; need not be a power of 2)
SEL_W, $clog2(NUM_REGS), select width; localparam, not overridable

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
bus_load  in  1  write databus into reg[bus_wsel]
bus_enable  in  1  drive reg[bus_rsel] onto databus
bus_wsel  in  SEL_W  bus write target
bus_rsel  in  SEL_W  bus read source
databus  inout  DATA_W  shared system bus
alu_asel  in  SEL_W  ALU operand A source
alu_bsel  in  SEL_W  ALU operand B source
alu_a  out  DATA_W  operand A
alu_b  out  DATA_W  operand B
wb_valid  in  1  ALU writeback strobe
wb_sel  in  SEL_W  writeback target
wb_data  in  DATA_W  writeback value
inc_en  in  1  reg[step_sel] += 1
dec_en  in  1  reg[step_sel] -= 1
step_sel  in  SEL_W  inc/dec target
step_wrap  out  1  registered; inc/dec wrapped last cycle
zero_flags  out  NUM_REGS  bit i = (reg[i]==0), combinational from state
bus_conflict  out  1  registered; illegal bus_load&bus_enable last cycle

Behaviour:
- Reset: has priority over all other inputs. All regs, step_wrap and bus_conflict go to 0. Databus is released to Z. zero_flags reads all ones.
- Reads: alu_a, alu_b and the databus value are combinational from the current register state (0-cycle).
- Writes: take effect at the rising edge; the new value is visible on the reads in the following cycle.
- Databus drive: driven with reg[bus_rsel] only when bus_enable=1 and bus_load=0; otherwise Z.
- Bus conflict: if bus_load=1 and bus_enable=1 in the same cycle:
  - the bus stays Z;
  - no bus write occurs;
  - bus_conflict=1 for exactly the next cycle.
- Per-register write priority when several sources target the same register: bus_load > wb_valid > inc/dec. The losing sources are dropped for that register.
- Sources targeting different registers all commit in the same cycle.
- Inc/dec both asserted: inc_en=1 with dec_en=1 is a no-op, and step_wrap=0.
- Inc/dec arithmetic is modulo 2^DATA_W:
  - inc from all-ones gives 0; dec from 0 gives all-ones.
  - step_wrap=1 for the next cycle only when a wrapping inc/dec actually commits.
  - A step pre-empted by a higher-priority write does not set step_wrap.
- Out-of-range selects (index >= NUM_REGS): reads return 0, writes and steps are ignored, step_wrap=0.
- Reset mid-operation: all pending writes in that cycle are discarded. Flags are cleared, not set.

Optional Feature:
Macro: REGFILE_BYPASS_EN
- Defined: alu_a and alu_b forward the same-cycle committing value when their select matches the winning write target. The forwarded value follows the same priority (bus data, then wb_data, then the stepped result). Databus reads and zero_flags are never bypassed.
- Undefined: all reads come from registered state only, as above.

Decomposition:
Package regfile_pkg holds:
- the write-source priority enum: SRC_NONE, SRC_BUS, SRC_WB, SRC_STEP;
- the default DATA_W and NUM_REGS constants.

Sub-module regfile_write_arb:
- Per-register priority and mux logic.
- Produces a write enable, next value and wrap bit for each register.
- Instantiated NUM_REGS times in a generate loop.

Test Plan:
- Reset then bus_load with bus_wsel=2, databus=8'hA5, then bus_enable with bus_rsel=2 -> databus=8'hA5 next cycle; zero_flags=4'b1011.
- wb_valid (wb_sel=1, wb_data=8'h3C) with bus_load (bus_wsel=1, bus=8'h77) in the same cycle -> reg1=8'h77. Repeat with bus_wsel=3 -> reg1=8'h3C and reg3=8'h77.
- reg0=8'hFF, inc_en with step_sel=0 -> reg0=8'h00, step_wrap=1 for one cycle, zero_flags[0]=1. Then dec_en -> reg0=8'hFF, step_wrap=1. Then inc_en with dec_en -> no change, step_wrap=0.
- bus_load=1 and bus_enable=1 together -> databus Z, no register change, bus_conflict=1 for exactly one cycle.
- alu_asel=1, alu_bsel=1 while wb writes 8'h10 to reg1 -> alu_a=alu_b=old value that cycle (8'h10 with REGFILE_BYPASS_EN), and 8'h10 the next cycle in both builds.
- NUM_REGS=5, DATA_W=16: a write to sel=6 is ignored and a read of sel=7 returns 0. Reset asserted in the same cycle as a writeback -> all registers 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multiport register file.
package regfile_pkg;

    localparam int DEFAULT_DATA_W   = 8;
    localparam int DEFAULT_NUM_REGS = 4;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_BUS,
        SRC_WB,
        SRC_STEP
    } write_src_e;

endpackage

// File: rtl/regfile_write_arb.sv
// Per-register write arbitration: picks bus > writeback > step and builds the next value and wrap bit.
module regfile_write_arb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] cur_value,
    input  logic              bus_hit,
    input  logic [DATA_W-1:0] bus_data,
    input  logic              wb_hit,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              inc_hit,
    input  logic              dec_hit,
    output logic              wr_en,
    output logic [DATA_W-1:0] next_value,
    output logic              wrap
);

    write_src_e        src;
    logic [DATA_W-1:0] stepped;
    logic              step_wraps;

    // inc and dec together cancel out, so only an exclusive request counts as a step
    always_comb begin
        src = SRC_NONE;
        if (bus_hit) begin
            src = SRC_BUS;
        end else if (wb_hit) begin
            src = SRC_WB;
        end else if (inc_hit ^ dec_hit) begin
            src = SRC_STEP;
        end
    end

    always_comb begin
        stepped    = cur_value;
        step_wraps = 1'b0;
        if (inc_hit) begin
            stepped    = cur_value + DATA_W'(1);
            step_wraps = &cur_value;
        end else begin
            stepped    = cur_value - DATA_W'(1);
            step_wraps = ~|cur_value;
        end
    end

    always_comb begin
        next_value = cur_value;
        wrap       = 1'b0;
        case (src)
            SRC_BUS:  next_value = bus_data;
            SRC_WB:   next_value = wb_data;
            SRC_STEP: begin
                next_value = stepped;
                wrap       = step_wraps;
            end
            default:  next_value = cur_value;
        endcase
        wr_en = (src != SRC_NONE);
    end

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file: tri-state databus port, two ALU read ports, writeback, inc/dec stepping.
// Optional REGFILE_BYPASS_EN forwards same-cycle committing values onto the ALU read ports.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = DEFAULT_DATA_W,
    parameter  int NUM_REGS = DEFAULT_NUM_REGS,
    localparam int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                bus_load,
    input  logic                bus_enable,
    input  logic [SEL_W-1:0]    bus_wsel,
    input  logic [SEL_W-1:0]    bus_rsel,
    inout  wire  [DATA_W-1:0]   databus,
    input  logic [SEL_W-1:0]    alu_asel,
    input  logic [SEL_W-1:0]    alu_bsel,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    input  logic                wb_valid,
    input  logic [SEL_W-1:0]    wb_sel,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                inc_en,
    input  logic                dec_en,
    input  logic [SEL_W-1:0]    step_sel,
    output logic                step_wrap,
    output logic [NUM_REGS-1:0] zero_flags,
    output logic                bus_conflict
);

    logic [DATA_W-1:0]   regs      [NUM_REGS];
    logic [DATA_W-1:0]   next_vals [NUM_REGS];
    logic [DATA_W-1:0]   alu_view  [NUM_REGS];
    logic [NUM_REGS-1:0] wr_en_vec;
    logic [NUM_REGS-1:0] wrap_vec;
    logic [DATA_W-1:0]   bus_rd_data;
    logic                bus_write;
    logic                bus_drive;

    // a simultaneous load and enable is a conflict: neither the write nor the drive happens
    assign bus_write = bus_load & ~bus_enable;
    assign bus_drive = bus_enable & ~bus_load & ~reset;

    assign databus = bus_drive ? bus_rd_data : {DATA_W{1'bz}};

    // out-of-range selects never match any index, so their writes and steps simply drop
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        regfile_write_arb #(
            .DATA_W(DATA_W)
        ) u_arb (
            .cur_value (regs[i]),
            .bus_hit   (bus_write && (bus_wsel == SEL_W'(i))),
            .bus_data  (databus),
            .wb_hit    (wb_valid && (wb_sel == SEL_W'(i))),
            .wb_data   (wb_data),
            .inc_hit   (inc_en && (step_sel == SEL_W'(i))),
            .dec_hit   (dec_en && (step_sel == SEL_W'(i))),
            .wr_en     (wr_en_vec[i]),
            .next_value(next_vals[i]),
            .wrap      (wrap_vec[i])
        );

        assign zero_flags[i] = (regs[i] == '0);

`ifdef REGFILE_BYPASS_EN
        assign alu_view[i] = wr_en_vec[i] ? next_vals[i] : regs[i];
`else
        assign alu_view[i] = regs[i];
`endif
    end

    // read muxes fall back to zero when the select points past the last register
    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        bus_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (alu_asel == SEL_W'(i)) alu_a = alu_view[i];
            if (alu_bsel == SEL_W'(i)) alu_b = alu_view[i];
            if (bus_rsel == SEL_W'(i)) bus_rd_data = regs[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            step_wrap    <= 1'b0;
            bus_conflict <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en_vec[i]) regs[i] <= next_vals[i];
            end
            step_wrap    <= |wrap_vec;
            bus_conflict <= bus_load & bus_enable;
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed self-checking bench for regfile_multiport: default 4x8 instance plus a 5x16 instance for range cases.
module tb_regfile_multiport;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    // 4 x 8-bit instance
    logic        bus_load, bus_enable;
    logic [1:0]  bus_wsel, bus_rsel, alu_asel, alu_bsel, wb_sel, step_sel;
    logic [7:0]  alu_a, alu_b, wb_data, tb_bus_data;
    logic        tb_bus_drive;
    logic        wb_valid, inc_en, dec_en, step_wrap, bus_conflict;
    logic [3:0]  zero_flags;
    wire  [7:0]  databus;

    assign databus = tb_bus_drive ? tb_bus_data : 8'bz;

    // 5 x 16-bit instance
    logic        b5_load, b5_enable;
    logic [2:0]  b5_wsel, b5_rsel, a5_asel, a5_bsel, wb5_sel, st5_sel;
    logic [15:0] a5_a, a5_b, wb5_data, tb5_bus_data;
    logic        tb5_bus_drive;
    logic        wb5_valid, inc5_en, dec5_en, step5_wrap, conflict5;
    logic [4:0]  zero5;
    wire  [15:0] databus5;

    assign databus5 = tb5_bus_drive ? tb5_bus_data : 16'bz;

    int check_count = 0;
    int pass_count  = 0;

    regfile_multiport u_dut (
        .clock(clock), .reset(reset),
        .bus_load(bus_load), .bus_enable(bus_enable),
        .bus_wsel(bus_wsel), .bus_rsel(bus_rsel), .databus(databus),
        .alu_asel(alu_asel), .alu_bsel(alu_bsel), .alu_a(alu_a), .alu_b(alu_b),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data),
        .inc_en(inc_en), .dec_en(dec_en), .step_sel(step_sel),
        .step_wrap(step_wrap), .zero_flags(zero_flags), .bus_conflict(bus_conflict)
    );

    regfile_multiport #(.DATA_W(16), .NUM_REGS(5)) u_dut5 (
        .clock(clock), .reset(reset),
        .bus_load(b5_load), .bus_enable(b5_enable),
        .bus_wsel(b5_wsel), .bus_rsel(b5_rsel), .databus(databus5),
        .alu_asel(a5_asel), .alu_bsel(a5_bsel), .alu_a(a5_a), .alu_b(a5_b),
        .wb_valid(wb5_valid), .wb_sel(wb5_sel), .wb_data(wb5_data),
        .inc_en(inc5_en), .dec_en(dec5_en), .step_sel(st5_sel),
        .step_wrap(step5_wrap), .zero_flags(zero5), .bus_conflict(conflict5)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        bus_load = 0; bus_enable = 0; bus_wsel = 0; bus_rsel = 0;
        alu_asel = 0; alu_bsel = 0; wb_valid = 0; wb_sel = 0; wb_data = 0;
        inc_en = 0; dec_en = 0; step_sel = 0; tb_bus_drive = 0; tb_bus_data = 0;
        b5_load = 0; b5_enable = 0; b5_wsel = 0; b5_rsel = 0;
        a5_asel = 0; a5_bsel = 0; wb5_valid = 0; wb5_sel = 0; wb5_data = 0;
        inc5_en = 0; dec5_en = 0; st5_sel = 0; tb5_bus_drive = 0; tb5_bus_data = 0;
    endtask

    // advance one rising edge and settle away from it
    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clearInputs();
        reset = 1;
        applyStimulus();
        applyStimulus();
        reset = 0;

        checkOutput("reset_zero_flags", 32'(zero_flags), 32'hF);
        checkOutput("reset_step_wrap", 32'(step_wrap), 32'h0);
        checkOutput("reset_bus_conflict", 32'(bus_conflict), 32'h0);
        checkOutput("reset_alu_a", 32'(alu_a), 32'h0);
        checkOutput("reset_zero5", 32'(zero5), 32'h1F);

        // bus load then bus read of reg2
        bus_load = 1; bus_wsel = 2; tb_bus_drive = 1; tb_bus_data = 8'hA5;
        applyStimulus();
        clearInputs();
        bus_enable = 1; bus_rsel = 2;
        #1;
        checkOutput("bus_read_reg2", 32'(databus), 32'hA5);
        checkOutput("zero_flags_after_load", 32'(zero_flags), 32'hB);
        clearInputs();

        // bus beats writeback on the same register
        bus_load = 1; bus_wsel = 1; tb_bus_drive = 1; tb_bus_data = 8'h77;
        wb_valid = 1; wb_sel = 1; wb_data = 8'h3C;
        applyStimulus();
        clearInputs();
        alu_asel = 1;
        #1;
        checkOutput("bus_over_wb_reg1", 32'(alu_a), 32'h77);

        // different targets both commit
        bus_load = 1; bus_wsel = 3; tb_bus_drive = 1; tb_bus_data = 8'h77;
        wb_valid = 1; wb_sel = 1; wb_data = 8'h3C;
        applyStimulus();
        clearInputs();
        alu_asel = 1; alu_bsel = 3;
        #1;
        checkOutput("split_wb_reg1", 32'(alu_a), 32'h3C);
        checkOutput("split_bus_reg3", 32'(alu_b), 32'h77);

        // increment wrap from all ones
        wb_valid = 1; wb_sel = 0; wb_data = 8'hFF;
        applyStimulus();
        clearInputs();
        inc_en = 1; step_sel = 0;
        applyStimulus();
        clearInputs();
        checkOutput("inc_wrap_value", 32'(alu_a), 32'h00);
        checkOutput("inc_wrap_flag", 32'(step_wrap), 32'h1);
        checkOutput("inc_wrap_zero0", 32'(zero_flags[0]), 32'h1);
        dec_en = 1; step_sel = 0;
        applyStimulus();
        clearInputs();
        checkOutput("dec_wrap_value", 32'(alu_a), 32'hFF);
        checkOutput("dec_wrap_flag", 32'(step_wrap), 32'h1);
        inc_en = 1; dec_en = 1; step_sel = 0;
        applyStimulus();
        clearInputs();
        checkOutput("incdec_noop_value", 32'(alu_a), 32'hFF);
        checkOutput("incdec_noop_wrap", 32'(step_wrap), 32'h0);

        // load and enable together: DUT must not drive, nothing written
        bus_load = 1; bus_enable = 1; bus_wsel = 0; bus_rsel = 2;
        tb_bus_drive = 1; tb_bus_data = 8'h0F;
        #1;
        checkOutput("conflict_bus_released", 32'(databus), 32'h0F);
        applyStimulus();
        clearInputs();
        checkOutput("conflict_no_write", 32'(alu_a), 32'hFF);
        checkOutput("conflict_flag_set", 32'(bus_conflict), 32'h1);
        applyStimulus();
        checkOutput("conflict_flag_clear", 32'(bus_conflict), 32'h0);

        // ALU reads during a writeback to the same register
        alu_asel = 1; alu_bsel = 1; wb_valid = 1; wb_sel = 1; wb_data = 8'h10;
        #1;
`ifdef REGFILE_BYPASS_EN
        checkOutput("same_cycle_alu_a", 32'(alu_a), 32'h10);
        checkOutput("same_cycle_alu_b", 32'(alu_b), 32'h10);
`else
        checkOutput("same_cycle_alu_a", 32'(alu_a), 32'h3C);
        checkOutput("same_cycle_alu_b", 32'(alu_b), 32'h3C);
`endif
        applyStimulus();
        wb_valid = 0;
        #1;
        checkOutput("next_cycle_alu_a", 32'(alu_a), 32'h10);
        checkOutput("next_cycle_alu_b", 32'(alu_b), 32'h10);
        clearInputs();

        // writeback pre-empts a wrapping increment
        wb_valid = 1; wb_sel = 0; wb_data = 8'h55; inc_en = 1; step_sel = 0;
        applyStimulus();
        clearInputs();
        checkOutput("preempt_value", 32'(alu_a), 32'h55);
        checkOutput("preempt_no_wrap", 32'(step_wrap), 32'h0);

        // three sources, three targets, one edge
        bus_load = 1; bus_wsel = 2; tb_bus_drive = 1; tb_bus_data = 8'h11;
        wb_valid = 1; wb_sel = 1; wb_data = 8'h22; inc_en = 1; step_sel = 3;
        applyStimulus();
        clearInputs();
        alu_asel = 2; alu_bsel = 1; bus_enable = 1; bus_rsel = 3;
        #1;
        checkOutput("multi_bus_reg2", 32'(alu_a), 32'h11);
        checkOutput("multi_wb_reg1", 32'(alu_b), 32'h22);
        checkOutput("multi_inc_reg3", 32'(databus), 32'h78);
        checkOutput("multi_inc_no_wrap", 32'(step_wrap), 32'h0);
        clearInputs();

        // wider, non power-of-two instance
        wb5_valid = 1; wb5_sel = 4; wb5_data = 16'h1234;
        applyStimulus();
        clearInputs();
        a5_asel = 4;
        #1;
        checkOutput("r5_write_reg4", 32'(a5_a), 32'h1234);
        checkOutput("r5_zero_after_reg4", 32'(zero5), 32'h0F);
        wb5_valid = 1; wb5_sel = 6; wb5_data = 16'hABCD;
        inc5_en = 1; st5_sel = 5;
        applyStimulus();
        clearInputs();
        a5_asel = 7; a5_bsel = 4;
        #1;
        checkOutput("r5_oor_write_ignored", 32'(zero5), 32'h0F);
        checkOutput("r5_oor_read_zero", 32'(a5_a), 32'h0);
        checkOutput("r5_reg4_intact", 32'(a5_b), 32'h1234);
        checkOutput("r5_oor_step_no_wrap", 32'(step5_wrap), 32'h0);
        clearInputs();
        dec5_en = 1; st5_sel = 0;
        applyStimulus();
        clearInputs();
        checkOutput("r5_dec_wrap_value", 32'(a5_a), 32'hFFFF);
        checkOutput("r5_dec_wrap_flag", 32'(step5_wrap), 32'h1);

        // reset wins over a same-cycle writeback
        reset = 1; wb5_valid = 1; wb5_sel = 2; wb5_data = 16'h5678; dec5_en = 1; st5_sel = 0;
        applyStimulus();
        reset = 0;
        clearInputs();
        a5_asel = 2; a5_bsel = 4;
        #1;
        checkOutput("r5_reset_zero_flags", 32'(zero5), 32'h1F);
        checkOutput("r5_reset_reg2", 32'(a5_a), 32'h0);
        checkOutput("r5_reset_reg4", 32'(a5_b), 32'h0);
        checkOutput("r5_reset_step_wrap", 32'(step5_wrap), 32'h0);
        checkOutput("reset_clears_small", 32'(zero_flags), 32'hF);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
